// File: rtl/aes_pkg.sv
// Shared types for the AES CBC decryption wrapper: block width, block type and FSM state encoding.
package aes_pkg;
    localparam int AES_BLK_W = 128;

    typedef logic [AES_BLK_W-1:0] aes_blk_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READY  = 2'd1,
        DECODE = 2'd2,
        OUT    = 2'd3
    } aes_state_e;
endpackage

// File: rtl/aes_blk_hold_reg.sv
// 128-bit load-enabled holding register with synchronous active-high clear.
module aes_blk_hold_reg
    import aes_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     en,
    input  aes_blk_t d,
    output aes_blk_t q
);
    aes_blk_t blk_d;
    aes_blk_t blk_q;

    always_comb begin
        blk_d = blk_q;
        if (en) begin
            blk_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blk_q <= '0;
        end else begin
            blk_q <= blk_d;
        end
    end

    assign q = blk_q;
endmodule

// File: rtl/aes_cbc_dec_chain.sv
// CBC chaining wrapper around a combinational AES-128 decryption core.
// Optional ECB bypass (ecb_mode port) is built when AES_CBC_ECB_BYPASS_EN is defined.
module aes_cbc_dec_chain
    import aes_pkg::*;
#(
    parameter int DEC_WAIT = 2,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iv_load,
    input  aes_blk_t         iv_data,
    input  logic             ct_valid,
    output logic             ct_ready,
    input  aes_blk_t         ct_data,
    input  logic             ct_last,
    output aes_blk_t         core_ct,
    input  aes_blk_t         core_pt,
    output logic             pt_valid,
    input  logic             pt_ready,
    output aes_blk_t         pt_data,
    output logic             pt_last,
    output logic [CNT_W-1:0] blk_count
`ifdef AES_CBC_ECB_BYPASS_EN
    ,
    input  logic             ecb_mode
`endif
);
    localparam logic [3:0] WAIT_INIT = 4'(DEC_WAIT - 1);

    aes_state_e       state_d, state_q;
    logic [3:0]       wait_cnt_d, wait_cnt_q;
    logic             last_d, last_q;
    logic             pt_valid_d, pt_valid_q;
    logic             pt_last_d, pt_last_q;
    logic [CNT_W-1:0] blk_count_d, blk_count_q;
    aes_blk_t         iv_d, iv_q;
    aes_blk_t         chain_nxt, chain_val, pt_nxt;
    logic             ct_en, chain_en, pt_en;
    logic             bypass;

`ifdef AES_CBC_ECB_BYPASS_EN
    logic ecb_d, ecb_q;
    assign bypass = ecb_q;
`else
    assign bypass = 1'b0;
`endif

    assign ct_ready = (state_q == READY) && !iv_load;
    assign pt_nxt   = bypass ? core_pt : (core_pt ^ chain_val);

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        last_d      = last_q;
        pt_valid_d  = pt_valid_q;
        pt_last_d   = pt_last_q;
        blk_count_d = blk_count_q;
        iv_d        = iv_q;
        chain_nxt   = iv_data;
        ct_en       = 1'b0;
        chain_en    = 1'b0;
        pt_en       = 1'b0;
`ifdef AES_CBC_ECB_BYPASS_EN
        ecb_d       = ecb_q;
`endif
        case (state_q)
            IDLE: begin
                if (iv_load) begin
                    iv_d     = iv_data;
                    chain_en = 1'b1;
                    state_d  = READY;
                end
`ifdef AES_CBC_ECB_BYPASS_EN
                else if (ecb_mode) begin
                    state_d = READY;
                end
`endif
            end
            READY: begin
                // A same-cycle IV reload wins; ct_ready is already low then.
                if (iv_load) begin
                    iv_d     = iv_data;
                    chain_en = 1'b1;
                end else if (ct_valid) begin
                    ct_en      = 1'b1;
                    last_d     = ct_last;
                    wait_cnt_d = WAIT_INIT;
                    state_d    = DECODE;
`ifdef AES_CBC_ECB_BYPASS_EN
                    ecb_d      = ecb_mode;
`endif
                end
            end
            DECODE: begin
                if (wait_cnt_q == 4'd0) begin
                    pt_en      = 1'b1;
                    pt_last_d  = last_q;
                    pt_valid_d = 1'b1;
                    // End of message rewinds the chain so the next message reuses the IV.
                    chain_en   = !bypass;
                    chain_nxt  = last_q ? iv_q : core_ct;
                    state_d    = OUT;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            OUT: begin
                if (pt_ready) begin
                    blk_count_d = pt_last_q ? '0 : blk_count_q + CNT_W'(1);
                    pt_valid_d  = 1'b0;
                    state_d     = READY;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            last_q      <= 1'b0;
            pt_valid_q  <= 1'b0;
            pt_last_q   <= 1'b0;
            blk_count_q <= '0;
            iv_q        <= '0;
`ifdef AES_CBC_ECB_BYPASS_EN
            ecb_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            last_q      <= last_d;
            pt_valid_q  <= pt_valid_d;
            pt_last_q   <= pt_last_d;
            blk_count_q <= blk_count_d;
            iv_q        <= iv_d;
`ifdef AES_CBC_ECB_BYPASS_EN
            ecb_q       <= ecb_d;
`endif
        end
    end

    aes_blk_hold_reg u_ct_reg (
        .clk (clk),
        .rst (rst),
        .en  (ct_en),
        .d   (ct_data),
        .q   (core_ct)
    );

    aes_blk_hold_reg u_chain_reg (
        .clk (clk),
        .rst (rst),
        .en  (chain_en),
        .d   (chain_nxt),
        .q   (chain_val)
    );

    aes_blk_hold_reg u_pt_reg (
        .clk (clk),
        .rst (rst),
        .en  (pt_en),
        .d   (pt_nxt),
        .q   (pt_data)
    );

    assign pt_valid  = pt_valid_q;
    assign pt_last   = pt_last_q;
    assign blk_count = blk_count_q;
endmodule

// File: tb/tb_aes_cbc_dec_chain.sv
// Directed bench for aes_cbc_dec_chain with a behavioural AES-128 inverse cipher acting as the core.
module tb_aes_cbc_dec_chain;
    import aes_pkg::*;

    localparam int DEC_WAIT = 2;
    localparam int CNT_W    = 16;
    localparam aes_blk_t KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam aes_blk_t CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam aes_blk_t IV2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam aes_blk_t PT1 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam aes_blk_t PT2 = 128'h3242f4ab8c5f368a393892a9ec3a093b;
    localparam aes_blk_t PT3 = 128'h0b6672b58a863976ed201d35f95d0c06;

    logic             clk = 1'b0;
    logic             rst;
    logic             iv_load;
    aes_blk_t         iv_data;
    logic             ct_valid;
    logic             ct_ready;
    aes_blk_t         ct_data;
    logic             ct_last;
    aes_blk_t         core_ct;
    aes_blk_t         core_pt;
    logic             pt_valid;
    logic             pt_ready;
    aes_blk_t         pt_data;
    logic             pt_last;
    logic [CNT_W-1:0] blk_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] sbox     [256];
    logic [7:0] inv_sbox [256];
    aes_blk_t   rk       [11];
    bit         tables_ready = 1'b0;

    always #5 clk = ~clk;

    aes_cbc_dec_chain #(.DEC_WAIT(DEC_WAIT), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .iv_load   (iv_load),
        .iv_data   (iv_data),
        .ct_valid  (ct_valid),
        .ct_ready  (ct_ready),
        .ct_data   (ct_data),
        .ct_last   (ct_last),
        .core_ct   (core_ct),
        .core_pt   (core_pt),
        .pt_valid  (pt_valid),
        .pt_ready  (pt_ready),
        .pt_data   (pt_data),
        .pt_last   (pt_last),
        .blk_count (blk_count)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    task automatic build_tables();
        logic [7:0]  inv, b, rcon;
        logic [31:0] w [44];
        logic [31:0] t;
        for (int i = 0; i < 256; i++) begin
            inv = 8'h00;
            for (int j = 1; j < 256; j++) begin
                if (gmul(8'(i), 8'(j)) == 8'h01) inv = 8'(j);
            end
            b = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sbox[i]     = b;
            inv_sbox[b] = 8'(i);
        end
        for (int i = 0; i < 4; i++) w[i] = KEY[127-32*i -: 32];
        rcon = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic aes_blk_t aes_dec(input aes_blk_t ct);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] a0, a1, a2, a3;
        aes_blk_t   v;
        v = ct ^ rk[10];
        for (int r = 9; r >= 0; r--) begin
            for (int b = 0; b < 16; b++) s[b] = v[127-8*b -: 8];
            // InvShiftRows (row rr rotates right by rr) fused with InvSubBytes.
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++)
                    t[4*c+rr] = inv_sbox[s[4*((c - rr + 4) % 4) + rr]];
            for (int b = 0; b < 16; b++) v[127-8*b -: 8] = t[b];
            v = v ^ rk[r];
            if (r > 0) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = v[127-32*c -: 8];
                    a1 = v[119-32*c -: 8];
                    a2 = v[111-32*c -: 8];
                    a3 = v[103-32*c -: 8];
                    v[127-32*c -: 8] = gmul(a0,8'h0e) ^ gmul(a1,8'h0b) ^ gmul(a2,8'h0d) ^ gmul(a3,8'h09);
                    v[119-32*c -: 8] = gmul(a0,8'h09) ^ gmul(a1,8'h0e) ^ gmul(a2,8'h0b) ^ gmul(a3,8'h0d);
                    v[111-32*c -: 8] = gmul(a0,8'h0d) ^ gmul(a1,8'h09) ^ gmul(a2,8'h0e) ^ gmul(a3,8'h0b);
                    v[103-32*c -: 8] = gmul(a0,8'h0b) ^ gmul(a1,8'h0d) ^ gmul(a2,8'h09) ^ gmul(a3,8'h0e);
                end
            end
        end
        return v;
    endfunction

    // Combinational decryption core between core_ct and core_pt.
    always @(core_ct or tables_ready) begin
        core_pt = tables_ready ? aes_dec(core_ct) : '0;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_iv(input aes_blk_t v);
        iv_load = 1'b1;
        iv_data = v;
        step();
        iv_load = 1'b0;
    endtask

    // Called one cycle after the ct handshake edge; returns cycles from handshake to pt_valid.
    task automatic wait_pt(output int lat);
        lat = 1;
        while (!pt_valid && lat < 20) begin
            step();
            lat++;
        end
    endtask

    task automatic run_block(input string tag, input logic last, input aes_blk_t exp_pt,
                             input logic [CNT_W-1:0] exp_cnt);
        int lat;
        ct_data  = CT;
        ct_last  = last;
        ct_valid = 1'b1;
        pt_ready = 1'b1;
        @(negedge clk);
        check({tag, " ct_ready"}, 128'(ct_ready), 128'(1));
        step();
        ct_valid = 1'b0;
        wait_pt(lat);
        check({tag, " latency"}, 128'(lat), 128'(DEC_WAIT + 1));
        check({tag, " pt_data"}, pt_data, exp_pt);
        check({tag, " pt_last"}, 128'(pt_last), 128'(last));
        $display("txn %s: pt=%h last=%0d latency=%0d", tag, pt_data, pt_last, lat);
        step();
        check({tag, " pt_valid drop"}, 128'(pt_valid), 128'(0));
        check({tag, " blk_count"}, 128'(blk_count), 128'(exp_cnt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        rst      = 1'b1;
        iv_load  = 1'b0;
        iv_data  = '0;
        ct_valid = 1'b0;
        ct_data  = '0;
        ct_last  = 1'b0;
        pt_ready = 1'b1;
        build_tables();
        tables_ready = 1'b1;
        repeat (3) step();
        rst = 1'b0;

        check("reset ct_ready", 128'(ct_ready), 128'(0));
        check("reset pt_valid", 128'(pt_valid), 128'(0));
        check("reset pt_last", 128'(pt_last), 128'(0));
        check("reset pt_data", pt_data, '0);
        check("reset core_ct", core_ct, '0);
        check("reset blk_count", 128'(blk_count), 128'(0));

        // Ciphertext offered before any IV is never accepted.
        ct_data  = CT;
        ct_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle ct_ready", 128'(ct_ready), 128'(0));
            step();
        end
        ct_valid = 1'b0;
        check("idle core_ct", core_ct, '0);

        load_iv('0);
        run_block("t1 iv0", 1'b1, PT1, 0);

        load_iv(IV2);
        run_block("t2 iv2", 1'b1, PT2, 0);

        load_iv('0);
        run_block("t3 blk1", 1'b0, PT1, 1);
        run_block("t3 blk2", 1'b1, PT3, 0);

        // Backpressure: a second block is offered while the first is stalled in OUT.
        load_iv('0);
        pt_ready = 1'b0;
        ct_data  = CT;
        ct_last  = 1'b1;
        ct_valid = 1'b1;
        step();
        wait_pt(lat);
        check("t4 latency", 128'(lat), 128'(DEC_WAIT + 1));
        for (int i = 0; i < 10; i++) begin
            check("t4 hold pt_valid", 128'(pt_valid), 128'(1));
            check("t4 hold pt_data", pt_data, PT1);
            check("t4 hold pt_last", 128'(pt_last), 128'(1));
            check("t4 hold ct_ready", 128'(ct_ready), 128'(0));
            step();
        end
        pt_ready = 1'b1;
        step();
        $display("txn t4 stalled: pt=%h released", PT1);
        check("t4 pt_valid drop", 128'(pt_valid), 128'(0));
        check("t4 ct_ready after", 128'(ct_ready), 128'(1));
        step();
        ct_valid = 1'b0;
        wait_pt(lat);
        check("t4 second latency", 128'(lat), 128'(DEC_WAIT + 1));
        check("t4 second pt_data", pt_data, PT1);
        $display("txn t4 second: pt=%h last=%0d latency=%0d", pt_data, pt_last, lat);
        step();

        // IV reload and ct offer collide in READY: ct is refused, new IV applies next.
        iv_load  = 1'b1;
        iv_data  = IV2;
        ct_data  = CT;
        ct_last  = 1'b1;
        ct_valid = 1'b1;
        @(negedge clk);
        check("t5 ct_ready with iv_load", 128'(ct_ready), 128'(0));
        step();
        iv_load  = 1'b0;
        ct_valid = 1'b0;
        repeat (DEC_WAIT + 2) step();
        check("t5 no accept", 128'(pt_valid), 128'(0));
        run_block("t5 new iv", 1'b1, PT2, 0);

        // Reset in DECODE discards the block and clears the count.
        load_iv('0);
        run_block("t6 pre", 1'b0, PT1, 1);
        ct_data  = CT;
        ct_last  = 1'b0;
        ct_valid = 1'b1;
        step();
        ct_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6 rst pt_valid", 128'(pt_valid), 128'(0));
        check("t6 rst ct_ready", 128'(ct_ready), 128'(0));
        check("t6 rst blk_count", 128'(blk_count), 128'(0));
        check("t6 rst core_ct", core_ct, '0);
        repeat (DEC_WAIT + 2) step();
        check("t6 discarded", 128'(pt_valid), 128'(0));
        load_iv('0);
        run_block("t6 post", 1'b1, PT1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/aes_cbc_dec_chain.md
Name: aes_cbc_dec_chain

Overview:
- Sequential CBC-mode wrapper placed directly downstream of the combinational AES-128 decryption core.
- Accepts ciphertext blocks over a valid/ready handshake and holds each block stable on the core input for a fixed settling time.
- Captures the core's plaintext output, XORs it with the chaining value (IV or previous ciphertext), and presents the result over an output valid/ready handshake.
- The core's cipher-key input is driven externally; this block does not touch it.

Parameters:
- DEC_WAIT, 2, cycles core_ct is held before core_pt is sampled (multicycle path through the core); legal range 1..15.
- CNT_W, 16, width of the block counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high; the only reset.
- iv_load  in  1  load a new IV; honoured only in IDLE or READY.
- iv_data  in  128  IV value.
- ct_valid  in  1  ciphertext block valid.
- ct_ready  out  1  block can accept ciphertext.
- ct_data  in  128  ciphertext block.
- ct_last  in  1  final block of the message; qualified by ct_valid.
- core_ct  out  128  to the decryption core's ciphertext input.
- core_pt  in  128  from the decryption core's plaintext output.
- pt_valid  out  1  plaintext valid.
- pt_ready  in  1  downstream accepts plaintext.
- pt_data  out  128  plaintext block.
- pt_last  out  1  pt_data is the final block of the message.
- blk_count  out  CNT_W  blocks delivered in the current message.

Behaviour:
- Reset values: state=IDLE; ct_ready=0, pt_valid=0, pt_last=0, pt_data=0, core_ct=0, blk_count=0; iv_reg, chain, ct_reg all 0.
- IDLE:
  - ct_ready=0.
  - On iv_load: iv_reg<=iv_data, chain<=iv_data, go to READY.
- READY:
  - ct_ready = ~iv_load (combinational).
  - iv_load: iv_reg and chain reload; any ct_valid in the same cycle is not accepted.
  - Handshake ct_valid&ct_ready: ct_reg<=ct_data, last_reg<=ct_last, wait_cnt<=DEC_WAIT-1, go to DECODE.
- DECODE:
  - core_ct = ct_reg, stable for the whole state.
  - wait_cnt decrements each cycle. When it reaches 0:
    - pt_data <= core_pt ^ chain; pt_last <= last_reg.
    - chain <= last_reg ? iv_reg : ct_reg.
    - Go to OUT.
  - iv_load is ignored.
- OUT:
  - pt_valid=1; pt_data and pt_last are held stable while pt_ready=0.
  - On pt_ready:
    - blk_count <= pt_last ? 0 : blk_count+1; wraps at 2^CNT_W-1 -> 0.
    - pt_valid drops next cycle; go to READY.
  - iv_load is ignored.
- Latency: ct handshake to pt_valid = DEC_WAIT+1 cycles.
- Throughput: one block per DEC_WAIT+2 cycles when pt_ready is held high.
- No buffering beyond one block in flight; ct_ready is 0 in DECODE and OUT.
- After ct_last the chain reverts to iv_reg, so the next message reuses the loaded IV unless iv_load occurs first.
- Reset mid-operation (any state): all state returns to reset values next cycle and the in-flight block is discarded; a new iv_load is required.
- core_ct holds ct_reg in every state except after reset, where it is 0.

Optional Feature:
- Macro AES_CBC_ECB_BYPASS_EN.
- Defined: adds input port ecb_mode (1 bit), sampled at the ct handshake into a per-block flag.
  - Flag set: pt_data = core_pt (no XOR) and chain is not updated.
  - ecb_mode=1 in IDLE allows entry to READY without iv_load.
- Undefined: no port; always CBC.

Decomposition:
- Package aes_pkg holds:
  - AES_BLK_W=128.
  - The state enum {IDLE, READY, DECODE, OUT} as a 2-bit typedef.
  - Typedef aes_blk_t = logic [127:0].
- One natural sub-module: aes_blk_hold_reg, the 128-bit load-enabled register, used for ct_reg, chain and pt_data.
- The FSM and counters stay in the top level.
- Benches instantiate the real decryption core between core_ct and core_pt, with key 2b7e151628aed2a6abf7158809cf4f3c.

Test Plan:
1. IV=0, ct=3925841d02dc09fbdc118597196a0b32, ct_last=1, pt_ready=1 -> pt_data=3243f6a8885a308d313198a2e0370734, pt_last=1, pt_valid exactly DEC_WAIT+1 cycles after the handshake, blk_count returns to 0.
2. IV=000102030405060708090a0b0c0d0e0f, same ct -> pt_data=3242f4ab8c5f368a393892a9ec3a093b.
3. Two-block message, IV=0, both blocks ct=3925841d…0b32:
   - Block 1 -> 3243f6a8885a308d313198a2e0370734.
   - Block 2 -> 0b6672b58a863976ed201d35f95d0c06.
   - blk_count reads 1 then 0.
4. Backpressure: hold pt_ready=0 for 10 cycles in OUT -> pt_data/pt_last stable, ct_ready=0 throughout, a block offered on ct is not accepted until after the pt handshake.
5. Before any IV load, ct_valid=1 -> ct_ready stays 0. In READY, iv_load and ct_valid in the same cycle -> ct is not accepted and the new IV is used for the following block.
6. rst asserted during DECODE -> next cycle pt_valid=0, ct_ready=0, blk_count=0. After a fresh IV load, scenario 1 passes.
